// File: rtl/plb_dac_wavegen_pkg.sv
// plb_dac_pkg: register map, mode encodings and field positions for the DAC waveform generator
package plb_dac_pkg;
  localparam int REG_CTRL = 0;
  localparam int REG_CONST = 1;
  localparam int REG_FIFO = 2;
  localparam int REG_STATUS = 3;
  localparam int REG_STEP = 4;
  typedef enum logic [1:0] {
    MODE_CONST = 2'b00,
    MODE_SAW = 2'b01,
    MODE_TRI = 2'b10,
    MODE_FIFO = 2'b11
  } mode_e;
  localparam int CTRL_EN = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_FMT = 3;
  localparam int CTRL_PWRDN = 4;
  localparam int CTRL_FCLR = 5;
  localparam int CTRL_DIV = 16;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_UDF = 2;
  localparam int ST_OVF = 3;
  localparam int ST_LEVEL = 8;
  localparam logic [31:0] CTRL_RST = 32'h0000_0010;
  // FIFO_CLR is a strobe and never stored, so it is masked out with the unused bits
  localparam logic [31:0] CTRL_MASK = 32'hFFFF_001F;
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) old[8*i +: 8] = wd[8*i +: 8];
    return old;
  endfunction
endpackage

// File: rtl/plb_dac_wavegen_if.sv
// plb_dac_wavegen_if: IPIF register-slave bus between the PLB IPIF and the DAC user logic
interface plb_dac_wavegen_if #(parameter int C_NUM_REG = 6);
  logic [0:31] Bus2IP_Data;
  logic [0:3] Bus2IP_BE;
  logic [0:C_NUM_REG-1] Bus2IP_RdCE;
  logic [0:C_NUM_REG-1] Bus2IP_WrCE;
  logic [0:31] IP2Bus_Data;
  logic IP2Bus_RdAck;
  logic IP2Bus_WrAck;
  logic IP2Bus_Error;
  modport master (
    output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    input IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
  modport slave (
    input Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/plb_dac_wavegen_fifo.sv
// dac_sample_fifo: synchronous sample FIFO with clear, level and per-cycle overflow/underflow pulses
module dac_sample_fifo #(
  parameter int W = 10,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic clr,
  input logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [AW:0] level,
  output logic ovf,
  output logic udf
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rp];
  assign ovf = push & ~do_push & ~clr;
  assign udf = pop & empty;
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/plb_dac_wavegen.sv
// plb_dac_wavegen: multi-channel PLB DAC waveform generator (const/saw/triangle/FIFO), round-robin onto one DAC bus
module plb_dac_wavegen import plb_dac_pkg::*; #(
  parameter int C_SLV_DWIDTH = 32,
  parameter int NUM_CH = 2,
  parameter int C_NUM_REG = 4 + NUM_CH,
  parameter int DAC_W = 10,
  parameter int PHASE_W = 16,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input logic Bus2IP_Clk,
  input logic Bus2IP_Reset,
  plb_dac_wavegen_if.slave bus,
  output logic [0:DAC_W-1] IP2DAC_Data,
  output logic IP2DAC_DCLKIO,
  output logic [CW-1:0] IP2DAC_Chan,
  output logic [NUM_CH-1:0] IP2DAC_OpEn,
  output logic IP2DAC_PWRDN
);
  logic [31:0] wd, wd_be, ctrl, rd;
  logic [3:0] be;
  logic [DAC_W-1:0] cnst, head, smp, data;
  logic [PHASE_W-1:0] step [NUM_CH];
  logic [PHASE_W-1:0] phase [NUM_CH];
  logic [PHASE_W-1:0] ph_n;
  logic [15:0] div, d, h, cnt;
  logic [CW-1:0] slot;
  logic [LW-1:0] level;
  logic en, fmt, tick, fclr, push, pop, full, empty, ovf, udf, ovf_st, udf_st;
  mode_e mode;
  assign wd = bus.Bus2IP_Data;
  assign be = bus.Bus2IP_BE;
  assign wd_be = be_merge('0, wd, be);
  assign en = ctrl[CTRL_EN];
  assign mode = mode_e'(ctrl[CTRL_MODE +: 2]);
  assign fmt = ctrl[CTRL_FMT];
  assign div = ctrl[CTRL_DIV +: 16];
  assign d = div == '0 ? 16'd1 : div;
  assign h = 16'((17'(d) + 17'd1) >> 1);
  // >= rather than == so a DIV shrunk mid-period ticks at once instead of wrapping cnt
  assign tick = en && cnt >= d;
  assign fclr = bus.Bus2IP_WrCE[REG_CTRL] && be[0] && wd[CTRL_FCLR];
  assign push = bus.Bus2IP_WrCE[REG_FIFO];
  assign pop = tick && mode == MODE_FIFO;
  assign ph_n = phase[slot] + step[slot];
  dac_sample_fifo #(.W(DAC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Bus2IP_Clk), .rst(Bus2IP_Reset), .push(push), .pop(pop), .clr(fclr),
    .wdata(wd_be[DAC_W-1:0]), .rdata(head), .full(full), .empty(empty),
    .level(level), .ovf(ovf), .udf(udf)
  );
  always_comb begin
    smp = mode == MODE_CONST ? cnst :
          mode == MODE_SAW ? ph_n[PHASE_W-1 -: DAC_W] :
          mode == MODE_TRI ? (ph_n[PHASE_W-1] ? ~ph_n[PHASE_W-2 -: DAC_W] : ph_n[PHASE_W-2 -: DAC_W]) : head;
    smp[DAC_W-1] = smp[DAC_W-1] ^ fmt;
  end
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      ctrl <= CTRL_RST;
      cnst <= '0;
      ovf_st <= 1'b0;
      udf_st <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) step[c] <= '0;
    end else begin
      ctrl <= bus.Bus2IP_WrCE[REG_CTRL] ? be_merge(ctrl, wd, be) & CTRL_MASK : ctrl;
      cnst <= bus.Bus2IP_WrCE[REG_CONST] ? DAC_W'(be_merge(32'(cnst), wd, be)) : cnst;
      for (int k = REG_STEP; k < C_NUM_REG; k++)
        if (bus.Bus2IP_WrCE[k]) step[k-REG_STEP] <= PHASE_W'(be_merge(32'(step[k-REG_STEP]), wd, be));
      ovf_st <= ovf | (ovf_st & ~(bus.Bus2IP_WrCE[REG_STATUS] & be[0] & wd[ST_OVF]));
      udf_st <= udf | (udf_st & ~(bus.Bus2IP_WrCE[REG_STATUS] & be[0] & wd[ST_UDF]));
    end
  end
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset || !en) begin
      cnt <= '0;
      slot <= '0;
      IP2DAC_Chan <= '0;
      data <= '0;
      IP2DAC_DCLKIO <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) phase[c] <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 16'd1;
      IP2DAC_DCLKIO <= !tick && cnt + 16'd1 >= h;
      if (tick) begin
        IP2DAC_Chan <= slot;
        slot <= slot == CW'(NUM_CH - 1) ? '0 : slot + 1'b1;
        phase[slot] <= ph_n;
        // an empty FIFO leaves the previous sample on the bus
        if (!(pop && empty)) data <= smp;
      end
    end
  end
  always_comb begin
    rd = '0;
    rd |= bus.Bus2IP_RdCE[REG_CTRL] ? ctrl : '0;
    rd |= bus.Bus2IP_RdCE[REG_CONST] ? 32'(cnst) : '0;
    rd |= bus.Bus2IP_RdCE[REG_FIFO] ? 32'(level) : '0;
    rd |= bus.Bus2IP_RdCE[REG_STATUS] ? {16'd0, 8'(level), 4'd0, ovf_st, udf_st, full, empty} : '0;
    for (int k = REG_STEP; k < C_NUM_REG; k++)
      rd |= bus.Bus2IP_RdCE[k] ? 32'(step[k-REG_STEP]) : '0;
  end
  assign bus.IP2Bus_Data = rd;
  assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
  assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
  assign bus.IP2Bus_Error = 1'b0;
  assign IP2DAC_Data = data;
  assign IP2DAC_OpEn = {NUM_CH{en}};
  assign IP2DAC_PWRDN = ctrl[CTRL_PWRDN];
endmodule

// File: doc/plb_dac_wavegen.md
# plb_dac_wavegen

Parametrised PLB DAC user-logic core that generates per-channel waveforms (constant, sawtooth, triangle, or software-streamed FIFO samples). Samples are time-multiplexed round-robin onto one DAC bus with a programmable sample-rate divider and data clock. It sits behind the PLB IPIF in the DAC pcore and replaces the fixed single-mode DAC user logic.

## Interface
- C_SLV_DWIDTH, 32: bus data width (fixed 32).
- NUM_CH, 2: channels, 1..4.
- C_NUM_REG, 4+NUM_CH: CE vector width.
- DAC_W, 10: DAC sample width, 8..16.
- PHASE_W, 16: phase accumulator width, ≥ DAC_W+1.
- FIFO_DEPTH, 16: sample FIFO entries, power of 2.
- Bus2IP_Clk  in  1  sole clock.
- Bus2IP_Reset  in  1  reset; synchronous, active-high.
- Bus2IP_Data  in  [0:31]  write data, big-endian (bit n = Bus2IP_Data[31-n]).
- Bus2IP_BE  in  [0:3]  byte enables; only bytes with BE=1 are written.
- Bus2IP_RdCE / Bus2IP_WrCE  in  [0:C_NUM_REG-1]  one-hot; CE bit k selects reg k.
- IP2Bus_Data  out  [0:31]  read data; 0 when no RdCE.
- IP2Bus_RdAck / IP2Bus_WrAck  out  1  OR of RdCE / WrCE (combinational).
- IP2Bus_Error  out  1  constant 0.
- IP2DAC_Data  out  [0:DAC_W-1]  registered sample.
- IP2DAC_DCLKIO  out  1  registered data clock.
- IP2DAC_Chan  out  max(1,clog2(NUM_CH))  channel of current sample.
- IP2DAC_OpEn  out  NUM_CH  per-channel output enable = EN.
- IP2DAC_PWRDN  out  1  = CTRL.PWRDN.

## Operation
- Registers: 0 CTRL, 1 CONST, 2 FIFO, 3 STATUS, 4+c STEP[c].
- CTRL: [0] EN, [2:1] MODE (00 const, 01 saw, 10 triangle, 11 FIFO), [3] FMT (1 inverts sample MSB, two's complement), [4] PWRDN, [5] FIFO_CLR (self-clearing, reads 0), [31:16] DIV. Reset 0x0000_0010.
- CONST[DAC_W-1:0]: constant sample. STEP[c][PHASE_W-1:0]: phase increment. Both reset 0.
- FIFO write: push [DAC_W-1:0]; read returns level. STATUS read: [0] empty, [1] full, [2] underflow, [3] overflow (sticky), [15:8] level; writing 1 to bit 2/3 clears it.
- Divider cnt counts 0..D, D = max(DIV,1); tick when cnt==D. Each tick: chan advances mod NUM_CH, sample for new chan computed and registered.
- Saw: phase[PHASE_W-1 -: DAC_W]. Triangle: phase MSB=0 → phase[PHASE_W-2 -: DAC_W], else its bitwise inverse. Phase of chan c += STEP[c] (mod 2^PHASE_W) when its slot is issued.
- FIFO mode: each tick pops one entry (entries interleaved ch0,ch1,...); empty → hold last Data, set underflow.
- Push when full without pop: dropped, set overflow. Push+pop when full: both succeed. Push+pop when empty: underflow, push succeeds. FIFO_CLR with push: clear wins.
- EN=0: cnt, chan, all phases → 0; Data=0, DCLK=0; FIFO contents kept.
- MODE/STEP/DIV changes apply from next tick; no phase reset.

## Timing
- Reset: all registers as above; Data 0, DCLKIO 0, Chan 0, OpEn 0, PWRDN 1, FIFO empty, sticky bits 0.
- Register write visible one cycle after WrCE; write side effects occur every cycle WrCE is high.
- Data/Chan update one cycle after tick (cnt==0); sample period D+1 clocks.
- DCLKIO = 0 while cnt < H, 1 while cnt ≥ H, H = (D+1)>>1, registered; rising edge mid-period.
- EN 0→1: first tick after D+1 clocks, chan 0 first... chan initialised so first issued slot is channel 0.

## Structure
- Package plb_dac_pkg: register indices, MODE encodings, CTRL bit positions, STATUS bit positions.
- Sub-module dac_sample_fifo: synchronous FIFO (DAC_W × FIFO_DEPTH), push/pop/clear, full/empty/level; single-cycle registered pop.

## Test plan
- Reset, read CTRL → 0x0000_0010; STATUS → 0x0000_0001; Data 0, PWRDN 1.
- CTRL=0x0003_0001 (DIV 3, const), CONST=0x155 → Data 0x155 every 4 clocks, DCLK 2 low/2 high, Chan 0,1,0,1.
- Saw, STEP[0]=0x0400, STEP[1]=0x0800, DIV 1, DAC_W 10 → ch0 0x010,0x020…, ch1 0x020,0x040…, wrap after 64/32 slots.
- Triangle, STEP[0]=0x4000 → ch0 samples 0x000,0x200,0x3FF,0x1FF (per inverse rule), repeating; FMT=1 flips MSB.
- FIFO: push 17 words (depth 16) → overflow=1, level 16; stream → 16 samples in order then underflow=1, Data holds last; W1C clears both.
- Mid-run EN=0 then Bus2IP_Reset pulse → outputs return to reset values next cycle; restart produces ch0 first.
